// File: rtl/wave_pkg.sv
// Shared definitions for the phase-to-waveform converter: mode encodings,
// offset-binary constants and the quarter-sine table generator.
package wave_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI = 2'd0,
        WAVE_SAW = 2'd1,
        WAVE_SQR = 2'd2,
        WAVE_SIN = 2'd3
    } wave_e;

    localparam longint QSINE_PI_Q = 64'sd843314857;  // pi in Q28
    localparam int     QSINE_FRAC = 28;

    function automatic int wave_mid(input int sample_w);
        return 1 << (sample_w - 1);
    endfunction

    function automatic int wave_max(input int sample_w);
        return (1 << sample_w) - 1;
    endfunction

    // round((MID-1) * sin(pi/2 * (k+0.5) / 2^(phase_w-2))) in integer fixed point,
    // so the table folds to constants without relying on real-valued math.
    function automatic int qsine_entry(input int k, input int phase_w, input int sample_w);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint amp;
        x    = (QSINE_PI_Q * longint'(2 * k + 1)) >>> phase_w;
        x2   = (x * x) >>> QSINE_FRAC;
        term = x;
        acc  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> QSINE_FRAC) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = longint'(wave_mid(sample_w) - 1);
        return int'((amp * acc + (longint'(1) <<< (QSINE_FRAC - 1))) >>> QSINE_FRAC);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude table with a CE-qualified registered read.
module quarter_sine_rom
    import wave_pkg::*;
#(
    parameter int PHASE_W  = 7,
    parameter int SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [PHASE_W-3:0]  addr,
    output logic [SAMPLE_W-2:0] data
);

    localparam int DEPTH = 2 ** (PHASE_W - 2);

    logic [SAMPLE_W-2:0] rom_tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
        localparam int ENTRY = qsine_entry(i, PHASE_W, SAMPLE_W);
        assign rom_tbl[i] = ENTRY[SAMPLE_W-2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (ce) begin
            data <= rom_tbl[addr];
        end
    end

endmodule

// File: rtl/phase2wave.sv
// Phase word to offset-binary sample converter, four waveforms, three CE stages.
// Waveform requests are only accepted on phase wrap (or the first CE after reset).
module phase2wave
    import wave_pkg::*;
#(
    parameter int PHASE_W  = 7,
    parameter int SAMPLE_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CE,
    input  logic [PHASE_W-1:0]  PHASE,
    input  logic [1:0]          MODE,
    output logic [SAMPLE_W-1:0] SAMPLE_OUT,
    output logic                VALID_OUT
);

    if (PHASE_W < 4 || SAMPLE_W < PHASE_W) begin : g_param_check
        $error("phase2wave: need PHASE_W >= 4 and SAMPLE_W >= PHASE_W");
    end

    localparam int                 S      = SAMPLE_W - PHASE_W;
    localparam logic [SAMPLE_W-1:0] MID_V  = SAMPLE_W'(wave_mid(SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] MID_M1 = MID_V - SAMPLE_W'(1);
    localparam logic [SAMPLE_W-1:0] MAX_V  = SAMPLE_W'(wave_max(SAMPLE_W));

    logic                first_ce;
    logic [PHASE_W-1:0]  prev_phase;
    wave_e               active_mode;
    logic [1:0]          fill;

    wave_e               eff_mode;
    logic [PHASE_W-2:0]  fold_idx;

    logic [PHASE_W-2:0]  s1_idx;
    logic                s1_half;
    wave_e               s1_mode;

    logic [SAMPLE_W-1:0] mag_next;
    logic [SAMPLE_W-1:0] s2_mag;
    logic                s2_half;
    wave_e               s2_mode;
    logic [SAMPLE_W-2:0] rom_data;
    logic [SAMPLE_W-1:0] rom_ext;

    logic [SAMPLE_W-1:0] s3_next;

    // Triangle and saw share the half-wave mirror; sine mirrors within the quarter.
    always_comb begin
        eff_mode = active_mode;
        if (first_ce || (PHASE < prev_phase)) begin
            eff_mode = wave_e'(MODE);
        end
        fold_idx = PHASE[PHASE_W-2:0];
        case (eff_mode)
            WAVE_TRI, WAVE_SAW: begin
                if (PHASE[PHASE_W-1]) begin
                    fold_idx = ~PHASE[PHASE_W-2:0];
                end
            end
            WAVE_SIN: begin
                if (PHASE[PHASE_W-2]) begin
                    fold_idx = {1'b1, ~PHASE[PHASE_W-3:0]};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mag_next = '0;
        case (s1_mode)
            WAVE_TRI: mag_next = SAMPLE_W'(s1_idx) << (S + 1);
            WAVE_SAW: mag_next = SAMPLE_W'(s1_idx) << S;
            default:  mag_next = '0;
        endcase
    end

    quarter_sine_rom #(
        .PHASE_W  (PHASE_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_rom (
        .clk  (CLK),
        .rst  (RST),
        .ce   (CE),
        .addr (s1_idx[PHASE_W-3:0]),
        .data (rom_data)
    );

    assign rom_ext = SAMPLE_W'(rom_data);

    always_comb begin
        s3_next = '0;
        case (s2_mode)
            WAVE_TRI: s3_next = s2_mag;
            WAVE_SAW: s3_next = s2_half ? (MAX_V - s2_mag) : s2_mag;
            WAVE_SQR: s3_next = s2_half ? '0 : MAX_V;
            WAVE_SIN: s3_next = s2_half ? (MID_M1 - rom_ext) : (MID_V + rom_ext);
            default:  s3_next = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            first_ce    <= 1'b1;
            prev_phase  <= '0;
            active_mode <= WAVE_TRI;
            fill        <= '0;
            s1_idx      <= '0;
            s1_half     <= 1'b0;
            s1_mode     <= WAVE_TRI;
            s2_mag      <= '0;
            s2_half     <= 1'b0;
            s2_mode     <= WAVE_TRI;
            SAMPLE_OUT  <= '0;
        end else if (CE) begin
            first_ce    <= 1'b0;
            prev_phase  <= PHASE;
            active_mode <= eff_mode;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
            s1_idx      <= fold_idx;
            s1_half     <= PHASE[PHASE_W-1];
            s1_mode     <= eff_mode;
            s2_mag      <= mag_next;
            s2_half     <= s1_half;
            s2_mode     <= s1_mode;
            SAMPLE_OUT  <= s3_next;
        end
    end

    assign VALID_OUT = (fill == 2'd3);

endmodule
